// File: rtl/uart_rx_fifo.sv
// UART receive buffer: edge-detected capture into a first-word-fall-through FIFO.
// Define UART_RX_FIFO_AFULL_EN to add the registered almost_full flag.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               Data_out,
    input  logic                     data_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_overflow
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    output logic                     almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of 2 in 2..256");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("uart_rx_fifo: AFULL_LEVEL must be in 1..DEPTH");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic          data_ready_q;
    logic          overflow_q;

    logic wr_ev;
    logic rd_fire;
    logic wr_acc;
    logic wr_drop;

    // data_ready may be a level or a pulse; only its rising edge is a byte
    assign wr_ev   = data_ready & ~data_ready_q;
    assign rd_fire = rd_valid & rd_ready;
    assign wr_acc  = wr_ev & (~full | rd_fire);
    assign wr_drop = wr_ev & full & ~rd_fire;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == DEPTH_L);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

    always_comb begin
        level_nxt = level_q;
        unique case ({wr_acc, rd_fire})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= Data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            data_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            data_ready_q <= data_ready;
            level_q      <= level_nxt;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // a drop in the same cycle as a clear leaves the flag set
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AFULL_EN
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_nxt >= AFULL_L);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue model.
// Define UART_RX_FIFO_AFULL_EN to also check almost_full.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       dr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rr;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic       clr;
`ifdef UART_RX_FIFO_AFULL_EN
    logic       af;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_drq;

    uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk(clk),
        .rst(rst),
        .Data_out(din),
        .data_ready(dr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rr),
        .level(level),
        .full(full),
        .overflow(overflow),
        .clr_overflow(clr)
`ifdef UART_RX_FIFO_AFULL_EN
        ,
        .almost_full(af)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and apply the FIFO rules to the queue model.
    task automatic cycle();
        bit we, rf, fl;
        we = dr && !m_drq;
        rf = (m_q.size() > 0) && rr;
        fl = (m_q.size() == DEPTH);
        if (rst) begin
            m_q.delete();
            m_ovf = 0;
            m_drq = 0;
        end else begin
            if (rf) void'(m_q.pop_front());
            if (we) begin
                if (!fl || rf) m_q.push_back(din);
                else m_ovf = 1;
            end
            if (!(we && fl && !rf) && clr) m_ovf = 0;
            m_drq = dr;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        dr = 1'b1;
        din = b;
        cycle();
        dr = 1'b0;
        cycle();
    endtask

    task automatic pop();
        rr = 1'b1;
        cycle();
        rr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        tests++;
        if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: level=%0d valid=%b full=%b want 0/0/0", level, rd_valid, full);
        end
        tests++;
        if (overflow !== 1'b0 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data: ovf=%b rd_data=%h want 0/00", overflow, rd_data);
        end
        dr = 1'b1;
        din = 8'h6C;
        cycle();
        rst = 1'b0;
        cycle();
        dr = 1'b0;
        tests++;
        if (level !== 5'd1 || rd_data !== 8'h6C) begin
            fails++;
            $display("FAIL reset_release_edge: level=%0d data=%h want 1/6c", level, rd_data);
        end
        pop();
        tests++;
        if (level !== 5'd0) begin
            fails++;
            $display("FAIL reset_release_drain: level=%0d want 0", level);
        end
    endtask

    task automatic test_single();
        dr = 1'b1;
        din = 8'hA1;
        cycle();
        dr = 1'b0;
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA1 || level !== 5'd1) begin
            fails++;
            $display("FAIL single_write: valid=%b data=%h level=%0d want 1/a1/1", rd_valid, rd_data, level);
        end
        pop();
        tests++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL single_read: valid=%b level=%0d want 0/0", rd_valid, level);
        end
    endtask

    task automatic test_level_held();
        dr = 1'b1;
        din = 8'h80;
        repeat (5) cycle();
        dr = 1'b0;
        cycle();
        tests++;
        if (level !== 5'd1 || rd_data !== 8'h80) begin
            fails++;
            $display("FAIL level_held: level=%0d data=%h want 1/80", level, rd_data);
        end
        pop();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) push(8'(i));
        tests++;
        if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fill: full=%b level=%0d ovf=%b want 1/16/0", full, level, overflow);
        end
        push(8'hFF);
        tests++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            fails++;
            $display("FAIL overflow_set: ovf=%b level=%0d want 1/16", overflow, level);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                fails++;
                $display("FAIL drain_%0d: valid=%b data=%h want 1/%h", i, rd_valid, rd_data, 8'(i));
            end
            pop();
        end
        tests++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL drain_end: valid=%b ovf=%b want 0/1", rd_valid, overflow);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL clr_overflow: ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] nxt_w = 8'h10;
        logic [7:0] nxt_r = 8'h10;
        int left = 40;
        while (left > 0) begin
            int n = (left < 3) ? left : 3;
            for (int i = 0; i < n; i++) begin
                push(nxt_w);
                nxt_w++;
                tests++;
                if (int'(level) > 3) begin
                    fails++;
                    $display("FAIL wrap_level: level=%0d want <=3", level);
                end
            end
            for (int i = 0; i < n; i++) begin
                tests++;
                if (rd_valid !== 1'b1 || rd_data !== nxt_r) begin
                    fails++;
                    $display("FAIL wrap_order: valid=%b data=%h want 1/%h", rd_valid, rd_data, nxt_r);
                end
                nxt_r++;
                pop();
            end
            left -= n;
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp[16];
        for (int i = 0; i < 16; i++) begin
            exp[i] = 8'($urandom);
            push(exp[i]);
        end
        tests++;
        if (rd_data !== exp[0] || full !== 1'b1) begin
            fails++;
            $display("FAIL full_rw_head: data=%h full=%b want %h/1", rd_data, full, exp[0]);
        end
        dr = 1'b1;
        din = 8'h5A;
        rr = 1'b1;
        cycle();
        dr = 1'b0;
        rr = 1'b0;
        tests++;
        if (overflow !== 1'b0 || level !== 5'd16) begin
            fails++;
            $display("FAIL full_rw: ovf=%b level=%0d want 0/16", overflow, level);
        end
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] want = (i == 16) ? 8'h5A : exp[i];
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== want) begin
                fails++;
                $display("FAIL full_rw_drain_%0d: data=%h want %h", i, rd_data, want);
            end
            pop();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 17; i++) push(8'(i + 8'h40));
        repeat (9) pop();
        tests++;
        if (level !== 5'd7 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: level=%0d ovf=%b want 7/1", level, overflow);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests++;
        if (level !== 5'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: level=%0d valid=%b ovf=%b want 0/0/0", level, rd_valid, overflow);
        end
        push(8'h33);
        tests++;
        if (rd_data !== 8'h33 || level !== 5'd1) begin
            fails++;
            $display("FAIL post_reset_first: data=%h level=%0d want 33/1", rd_data, level);
        end
        pop();
`ifdef UART_RX_FIFO_AFULL_EN
        for (int i = 0; i < 11; i++) push(8'(i));
        tests++;
        if (af !== 1'b0) begin
            fails++;
            $display("FAIL afull_11: af=%b want 0", af);
        end
        push(8'hEE);
        tests++;
        if (af !== 1'b1) begin
            fails++;
            $display("FAIL afull_12: af=%b want 1", af);
        end
        pop();
        tests++;
        if (af !== 1'b0) begin
            fails++;
            $display("FAIL afull_fall: af=%b want 0", af);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int rpct = (c < 300) ? 25 : 75;
            dr  = ($urandom_range(0, 1) == 1);
            din = 8'($urandom);
            rr  = ($urandom_range(0, 99) < rpct);
            clr = ($urandom_range(0, 15) == 0);
            if (m_q.size() > 0) begin
                tests++;
                if (rd_data !== m_q[0]) begin
                    fails++;
                    $display("FAIL rand_data c=%0d: data=%h want %h", c, rd_data, m_q[0]);
                end
            end
            cycle();
            tests++;
            if (int'(level) != m_q.size() || rd_valid !== (m_q.size() > 0) ||
                full !== (m_q.size() == DEPTH) || overflow !== m_ovf) begin
                fails++;
                $display("FAIL rand_state c=%0d: level=%0d valid=%b full=%b ovf=%b want %0d/%b", c, level, rd_valid, full, overflow, m_q.size(), m_ovf);
            end
`ifdef UART_RX_FIFO_AFULL_EN
            tests++;
            if (af !== (m_q.size() >= AFULL)) begin
                fails++;
                $display("FAIL rand_afull c=%0d: af=%b level=%0d", c, af, m_q.size());
            end
`endif
        end
        dr = 1'b0;
        rr = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dr = 1'b0;
        din = 8'h00;
        rr = 1'b0;
        clr = 1'b0;
        m_ovf = 0;
        m_drq = 0;
        test_reset();
        test_single();
        test_level_held();
        test_fill_overflow();
        test_wrap();
        test_full_rw();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer placed directly downstream of UART_RX. Captures each byte UART_RX presents on Data_out when its data_ready strobe rises, and stores it in a first-word-fall-through FIFO. Offers the bytes to the consumer (command parser, bus bridge) over a valid/ready read handshake. Detects and flags overflow so bursts on the serial line do not silently corrupt the stream.

Parameters:
DEPTH, 16, number of byte entries; must be a power of 2, 2..256.
AFULL_LEVEL, 12, almost-full threshold in entries, 1..DEPTH (used only with the optional feature).

Ports:
clk  input  1  system clock; same clock as UART_RX.
rst  input  1  synchronous active-high reset.
Data_out  input  8  received byte from UART_RX.
data_ready  input  1  byte-valid strobe from UART_RX; level or pulse, edge-detected here.
rd_data  output  8  byte at FIFO head; valid when rd_valid=1.
rd_valid  output  1  FIFO non-empty.
rd_ready  input  1  consumer accepts rd_data this cycle.
level  output  $clog2(DEPTH)+1  current number of stored entries, 0..DEPTH.
full  output  1  level==DEPTH.
overflow  output  1  sticky: a byte was dropped because the FIFO was full.
clr_overflow  input  1  clears overflow.
almost_full  output  1  only with the optional feature.

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=rd_ptr=0, level=0, rd_valid=0, full=0, overflow=0, almost_full=0, rd_data=8'h00. The data_ready edge-detect register is cleared, so a data_ready held high through reset release counts as a new edge. Reset mid-burst discards all stored bytes; memory contents need not be cleared.
- Write event (wr_ev) = data_ready & ~data_ready_q. data_ready_q is data_ready registered on clk. A level held for N cycles produces exactly one write.
- Write accepted = wr_ev & (~full | rd_fire), where rd_fire = rd_valid & rd_ready. On acceptance: mem[wr_ptr] <= Data_out, and wr_ptr increments modulo DEPTH (natural wrap, no skip).
- Write dropped = wr_ev & full & ~rd_fire. Effects: overflow <= 1, contents unchanged, level stays DEPTH.
- Read: FWFT. rd_data always reflects mem[rd_ptr] while rd_valid=1. On rd_fire, rd_ptr increments modulo DEPTH. rd_ready is ignored while rd_valid=0 and causes no pointer change.
- Latency: a byte whose wr_ev is sampled at edge N is visible on rd_data with rd_valid=1 in the cycle after edge N. It may be consumed at edge N+1.
- level update:
  - +1 on an accepted write without rd_fire.
  - -1 on rd_fire without a write.
  - unchanged on both or neither.
  - full and rd_valid are derived from level (registered or decoded, but consistent in the same cycle).
- Simultaneous read+write when full: write accepted, level stays DEPTH, no overflow.
- Simultaneous read+write when empty: no read (rd_valid=0); write accepted, level becomes 1.
- clr_overflow: overflow <= 0 at the next edge. If a drop occurs in the same cycle as clr_overflow, the set wins (overflow=1).
- No combinational path from Data_out or data_ready to any output. rd_ready feeds the write-accept logic only.

Optional Feature:
UART_RX_FIFO_AFULL_EN
- Defined: almost_full port exists. almost_full is registered and equals (level >= AFULL_LEVEL) after each edge, and is 0 in reset. It is intended for RTS/CTS-style flow control back to the remote transmitter.
- Undefined: the almost_full port and its logic are absent, and AFULL_LEVEL is unused.

Test Plan:
1. Single byte: after reset, pulse data_ready for 1 cycle with Data_out=8'hA1 and hold rd_ready=0 -> next cycle rd_valid=1, rd_data=8'hA1, level=1. Then assert rd_ready for 1 cycle -> rd_valid=0, level=0.
2. Level-held strobe: hold data_ready=1 for 5 cycles with Data_out=8'h80 -> exactly one entry (level=1), rd_data=8'h80.
3. Fill and overflow: write 16 bytes 8'h00..8'h0F with rd_ready=0 -> full=1, level=16. A 17th write of 8'hFF -> overflow=1, level=16. Draining reads 8'h00..8'h0F in order with no 8'hFF. Pulse clr_overflow -> overflow=0.
4. Wrap-around: repeatedly write 3 and read 3 over 40 bytes (8'h10..8'h37) -> output sequence identical to input, level never exceeds 3.
5. Full with simultaneous read/write: at level=16, a wr_ev of 8'h5A in the same cycle as rd_fire -> overflow stays 0, level=16. 8'h5A emerges 16th after that read.
6. Reset mid-operation: at level=7, assert rst for 1 cycle -> level=0, rd_valid=0, overflow=0. Next write 8'h33 is read first. With UART_RX_FIFO_AFULL_EN: almost_full rises when level reaches 12 and falls when level drops to 11.
